// File: rtl/i2c_bus_condition_gen_pkg.sv
// Shared encodings for the I2C bus-condition sequencer: commands, condition
// states and the (scl, sda) line levels each state drives.
package i2c_pkg;

    localparam logic [1:0] CMD_START  = 2'd1;
    localparam logic [1:0] CMD_RSTART = 2'd2;
    localparam logic [1:0] CMD_STOP   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST_SETUP,
        S_ST_HOLD,
        S_ST_LOW,
        S_OWNED,
        S_RS_SDA,
        S_RS_SCL,
        S_SP_SDA,
        S_SP_SCL,
        S_SP_REL
    } cond_state_e;

    // Line pairs packed as {scl, sda}; 1 releases the open-drain line.
    localparam logic [1:0] k_lines_rel    = 2'b11;
    localparam logic [1:0] k_lines_low    = 2'b00;
    localparam logic [1:0] k_lines_scl_hi = 2'b10;
    localparam logic [1:0] k_lines_sda_hi = 2'b01;

    function automatic logic [1:0] state_lines(input cond_state_e s);
        logic [1:0] lines;
        lines = k_lines_rel;
        case (s)
            S_IDLE:     lines = k_lines_rel;
            S_ST_SETUP: lines = k_lines_rel;
            S_ST_HOLD:  lines = k_lines_scl_hi;
            S_ST_LOW:   lines = k_lines_low;
            S_OWNED:    lines = k_lines_low;
            S_RS_SDA:   lines = k_lines_sda_hi;
            S_RS_SCL:   lines = k_lines_rel;
            S_SP_SDA:   lines = k_lines_low;
            S_SP_SCL:   lines = k_lines_scl_hi;
            S_SP_REL:   lines = k_lines_rel;
            default:    lines = k_lines_rel;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/i2c_bus_condition_gen_sync2.sv
// Two-flop synchroniser for asynchronous pad readback; resets to the
// released (high) level so an idle bus reads as free straight out of reset.
module i2c_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2c_bus_condition_gen.sv
// I2C START / repeated START / STOP sequencer driving open-drain SCL/SDA,
// with per-phase divisor timing, clock-stretch hold and arbitration checks.
module i2c_bus_condition_gen
    import i2c_pkg::*;
#(
    parameter int CTR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CTR_WIDTH-1:0] dbl_clock_divisor,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd,
    output logic                 cmd_ready,
    output logic                 done,
    output logic                 cmd_err,
    output logic                 arb_lost,
    output logic                 bus_owned,
    input  logic                 scl_in,
    input  logic                 sda_in,
    output logic                 scl_out,
    output logic                 sda_out
);

    cond_state_e state_q, state_d;
    cond_state_e first_state;

    logic [CTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [CTR_WIDTH-1:0] div_q, div_d;

    logic scl_out_q, scl_out_d;
    logic sda_out_q, sda_out_d;
    logic cmd_ready_q, cmd_ready_d;
    logic done_q, done_d;
    logic cmd_err_q, cmd_err_d;
    logic arb_lost_q, arb_lost_d;
    logic bus_owned_q, bus_owned_d;

    logic scl_sync, sda_sync;
    logic phase_end, stretch_hold, reject;

    i2c_sync2 u_sync_scl (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (scl_in),
        .q     (scl_sync)
    );

    i2c_sync2 u_sync_sda (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sda_in),
        .q     (sda_sync)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        cmd_ready_d = cmd_ready_q;
        bus_owned_d = bus_owned_q;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;
        arb_lost_d  = 1'b0;
        first_state = S_IDLE;
        reject      = 1'b0;

        phase_end    = (cnt_q == div_q);
        // A slave holding SCL low freezes the phase that waits for SCL high.
        stretch_hold = ((state_q == S_RS_SCL) || (state_q == S_SP_SCL)) && !scl_sync;

        case (state_q)
            S_IDLE, S_OWNED: begin
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd)
                        CMD_START: begin
                            first_state = bus_owned_q ? S_RS_SDA : S_ST_SETUP;
                        end
                        CMD_RSTART: begin
                            if (bus_owned_q) first_state = S_RS_SDA;
                            else             reject      = 1'b1;
                        end
                        CMD_STOP: begin
                            if (bus_owned_q) first_state = S_SP_SDA;
                            else             reject      = 1'b1;
                        end
                        default: reject = 1'b1;
                    endcase

                    if (reject) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d     = first_state;
                        cnt_d       = '0;
                        div_d       = dbl_clock_divisor;
                        cmd_ready_d = 1'b0;
                    end
                end
            end

            default: begin
                if (stretch_hold) begin
                    cnt_d = '0;
                end else if (!phase_end) begin
                    cnt_d = cnt_q + CTR_WIDTH'(1);
                end else begin
                    cnt_d = '0;
                    case (state_q)
                        S_ST_SETUP: begin
                            // Another master pulled SDA low while we wanted it high.
                            if (!sda_sync) begin
                                state_d     = S_IDLE;
                                arb_lost_d  = 1'b1;
                                bus_owned_d = 1'b0;
                                cmd_ready_d = 1'b1;
                            end else begin
                                state_d = S_ST_HOLD;
                            end
                        end
                        S_ST_HOLD: state_d = S_ST_LOW;
                        S_ST_LOW: begin
                            state_d     = S_OWNED;
                            done_d      = 1'b1;
                            bus_owned_d = 1'b1;
                            cmd_ready_d = 1'b1;
                        end
                        S_RS_SDA: state_d = S_RS_SCL;
                        S_RS_SCL: state_d = S_ST_HOLD;
                        S_SP_SDA: state_d = S_SP_SCL;
                        S_SP_SCL: state_d = S_SP_REL;
                        S_SP_REL: begin
                            state_d     = S_IDLE;
                            bus_owned_d = 1'b0;
                            cmd_ready_d = 1'b1;
                            if (!sda_sync) arb_lost_d = 1'b1;
                            else           done_d     = 1'b1;
                        end
                        default: begin
                            state_d     = S_IDLE;
                            bus_owned_d = 1'b0;
                            cmd_ready_d = 1'b1;
                        end
                    endcase
                end
            end
        endcase

        {scl_out_d, sda_out_d} = state_lines(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            scl_out_q   <= 1'b1;
            sda_out_q   <= 1'b1;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            arb_lost_q  <= 1'b0;
            bus_owned_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            scl_out_q   <= scl_out_d;
            sda_out_q   <= sda_out_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
            arb_lost_q  <= arb_lost_d;
            bus_owned_q <= bus_owned_d;
        end
    end

    assign scl_out   = scl_out_q;
    assign sda_out   = sda_out_q;
    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign cmd_err   = cmd_err_q;
    assign arb_lost  = arb_lost_q;
    assign bus_owned = bus_owned_q;

endmodule

// File: tb/tb_i2c_bus_condition_gen.sv
// Scoreboard bench for i2c_bus_condition_gen: expected line transitions and
// completion events are queued at command issue and matched as they appear.
module tb_i2c_bus_condition_gen;

    localparam logic [1:0] C_START  = 2'd1;
    localparam logic [1:0] C_RSTART = 2'd2;
    localparam logic [1:0] C_STOP   = 2'd3;

    localparam int K_DONE = 4;
    localparam int K_ARB  = 2;
    localparam int K_ERR  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dbl_clock_divisor;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready, done, cmd_err, arb_lost, bus_owned;
    logic        scl_in, sda_in, scl_out, sda_out;

    typedef struct { int cyc; int v; } ln_t;
    typedef struct { int cyc; int kind; int owned; } ev_t;

    ln_t ln_q[$];
    ev_t ev_q[$];
    ln_t lm;
    ev_t em;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    bit   m_owned = 1'b0;
    logic [1:0] prev_ln = 2'b11;
    int   a_cyc;

    i2c_bus_condition_gen #(.CTR_WIDTH(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dbl_clock_divisor (dbl_clock_divisor),
        .cmd_valid         (cmd_valid),
        .cmd               (cmd),
        .cmd_ready         (cmd_ready),
        .done              (done),
        .cmd_err           (cmd_err),
        .arb_lost          (arb_lost),
        .bus_owned         (bus_owned),
        .scl_in            (scl_in),
        .sda_in            (sda_in),
        .scl_out           (scl_out),
        .sda_out           (sda_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if ({scl_out, sda_out} != prev_ln) begin
                if (ln_q.size() == 0) begin
                    chk("line_unexpected", ln_q.size(), 1);
                end else begin
                    lm = ln_q.pop_front();
                    chk("line_val", int'({scl_out, sda_out}), lm.v);
                    chk("line_cyc", cyc, lm.cyc);
                end
                prev_ln = {scl_out, sda_out};
            end
            if (done || arb_lost || cmd_err) begin
                if (ev_q.size() == 0) begin
                    chk("event_unexpected", ev_q.size(), 1);
                end else begin
                    em = ev_q.pop_front();
                    chk("ev_kind", int'({done, arb_lost, cmd_err}), em.kind);
                    chk("ev_cyc", cyc, em.cyc);
                    chk("ev_owned", int'(bus_owned), em.owned);
                end
            end
        end
    end

    // Called just after a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [1:0] c, input int d, input int extra, input bit arb);
        int p;
        p = d + 1;
        a_cyc = cyc + 1;
        chk("ready_before_issue", int'(cmd_ready), 1);
        case (c)
            C_START: begin
                if (m_owned) begin
                    ln_q.push_back('{a_cyc, 1});
                    ln_q.push_back('{a_cyc + p, 3});
                    ln_q.push_back('{a_cyc + 2*p, 2});
                    ln_q.push_back('{a_cyc + 3*p, 0});
                    ev_q.push_back('{a_cyc + 4*p, K_DONE, 1});
                end else if (arb) begin
                    ev_q.push_back('{a_cyc + p, K_ARB, 0});
                end else begin
                    ln_q.push_back('{a_cyc + p, 2});
                    ln_q.push_back('{a_cyc + 2*p, 0});
                    ev_q.push_back('{a_cyc + 3*p, K_DONE, 1});
                    m_owned = 1'b1;
                end
            end
            C_RSTART: begin
                if (m_owned) begin
                    ln_q.push_back('{a_cyc, 1});
                    ln_q.push_back('{a_cyc + p, 3});
                    ln_q.push_back('{a_cyc + 2*p, 2});
                    ln_q.push_back('{a_cyc + 3*p, 0});
                    ev_q.push_back('{a_cyc + 4*p, K_DONE, 1});
                end else begin
                    ev_q.push_back('{a_cyc, K_ERR, 0});
                end
            end
            C_STOP: begin
                if (m_owned) begin
                    ln_q.push_back('{a_cyc + p, 2});
                    ln_q.push_back('{a_cyc + 2*p + extra, 3});
                    ev_q.push_back('{a_cyc + 3*p + extra, K_DONE, 0});
                    m_owned = 1'b0;
                end else begin
                    ev_q.push_back('{a_cyc, K_ERR, 0});
                end
            end
            default: ev_q.push_back('{a_cyc, K_ERR, int'(m_owned)});
        endcase
        cmd_valid         = 1'b1;
        cmd               = c;
        dbl_clock_divisor = 16'(d);
        @(negedge clk);
        cmd_valid         = 1'b0;
        cmd               = 2'd0;
        dbl_clock_divisor = 16'hFFFF;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (ev_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (ev_q.size() != 0) begin
            chk("timeout_pending_events", ev_q.size(), 0);
            ev_q.delete();
            ln_q.delete();
        end
        chk("lines_left", ln_q.size(), 0);
    endtask

    initial begin
        rst_n             = 1'b0;
        cmd_valid         = 1'b0;
        cmd               = 2'd0;
        dbl_clock_divisor = 16'd0;
        scl_in            = 1'b1;
        sda_in            = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_scl_out", int'(scl_out), 1);
        chk("rst_sda_out", int'(sda_out), 1);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        chk("rst_arb_lost", int'(arb_lost), 0);
        chk("rst_bus_owned", int'(bus_owned), 0);

        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk); #1;

        // START D=3, then RSTART and STOP at D=0, each issued in the done cycle
        issue(C_START, 3, 0, 1'b0);
        wait_idle(100);
        issue(C_RSTART, 0, 0, 1'b0);
        wait_idle(100);
        issue(C_STOP, 0, 0, 1'b0);
        wait_idle(100);

        // rejected commands while idle
        issue(C_STOP, 2, 0, 1'b0);
        wait_idle(20);
        issue(C_RSTART, 1, 0, 1'b0);
        wait_idle(20);
        issue(2'd0, 1, 0, 1'b0);
        wait_idle(20);

        // arbitration loss in the START setup phase
        issue(C_START, 3, 0, 1'b1);
        sda_in = 1'b0;
        wait_idle(100);
        m_owned = 1'b0;
        sda_in  = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        // START while owned resolves to a repeated START; cmd 0 rejected while owned
        issue(C_START, 0, 0, 1'b0);
        wait_idle(100);
        issue(C_START, 1, 0, 1'b0);
        wait_idle(100);
        issue(2'd0, 0, 0, 1'b0);
        wait_idle(20);

        // STOP D=2 with SCL held low by a slave until 10 cycles into S_SP_SCL
        issue(C_STOP, 2, 12, 1'b0);
        scl_in = 1'b0;
        while (cyc < a_cyc + 13) @(negedge clk);
        scl_in = 1'b1;
        wait_idle(200);

        // asynchronous reset in the middle of a repeated START
        issue(C_START, 0, 0, 1'b0);
        wait_idle(100);
        issue(C_RSTART, 3, 0, 1'b0);
        @(negedge clk);
        chk("mid_rs_scl_out", int'(scl_out), 0);
        chk("mid_rs_sda_out", int'(sda_out), 1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_scl_out", int'(scl_out), 1);
        chk("async_rst_sda_out", int'(sda_out), 1);
        chk("async_rst_cmd_ready", int'(cmd_ready), 1);
        chk("async_rst_bus_owned", int'(bus_owned), 0);
        ev_q.delete();
        ln_q.delete();
        m_owned = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/i2c_bus_condition_gen.md
# i2c_bus_condition_gen

Parametrised I2C bus-condition sequencer for the I2C master. It generates START, repeated START and STOP conditions on open-drain SCL/SDA, timing each phase against a programmable half-period divisor. It also handles slave clock stretching and SDA arbitration loss. It sits between the master's command FSM and the pad drivers, and hands the bus to the byte engine with SCL and SDA held low after a START.

## Interface
- `CTR_WIDTH`, 16: width of divisor and phase counter.
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `dbl_clock_divisor`  in  CTR_WIDTH: phase length minus one, in `clk` cycles; latched on command accept.
- `cmd_valid`  in  1: command request.
- `cmd`  in  2: `CMD_START`=1, `CMD_RSTART`=2, `CMD_STOP`=3; 0 is reserved.
- `cmd_ready`  out  1: the block can accept a command.
- `done`  out  1: one-cycle pulse when a condition completes successfully.
- `cmd_err`  out  1: one-cycle pulse when a command is rejected.
- `arb_lost`  out  1: one-cycle pulse on arbitration loss.
- `bus_owned`  out  1: this master holds the bus; set after a START and cleared after a STOP or arbitration loss.
- `scl_in`, `sda_in`  in  1 each: pad readback, asynchronous.
- `scl_out`, `sda_out`  out  1 each: 1 releases the line, 0 drives it low.

## Operation
- Reset values: `scl_out`=1, `sda_out`=1, `cmd_ready`=1, `done`=0, `cmd_err`=0, `arb_lost`=0, `bus_owned`=0; state is `S_IDLE`; counter is 0.
- Accept rule: a command is accepted when `cmd_valid && cmd_ready`.
  - On accept, the divisor is latched as D, the counter is cleared and the first phase is entered.
  - `cmd_ready` stays low until the condition ends.
- Phase rule: a phase ends in the cycle where counter == D. On that edge the FSM moves to the next phase and the counter goes to 0; otherwise the counter increments. Each phase therefore lasts D+1 cycles, and D=0 gives 1 cycle per phase.
- Phase sequences, written as (scl, sda):
  - START: `S_ST_SETUP`(1,1) → `S_ST_HOLD`(1,0) → `S_ST_LOW`(0,0) → `S_OWNED`.
  - RSTART: `S_RS_SDA`(0,1) → `S_RS_SCL`(1,1) → `S_ST_HOLD` → `S_ST_LOW` → `S_OWNED`.
  - STOP: `S_SP_SDA`(0,0) → `S_SP_SCL`(1,0) → `S_SP_REL`(1,1) → `S_IDLE`.
- Idle outputs: `S_IDLE` drives (1,1); `S_OWNED` drives (0,0).
- Command resolution:
  - `CMD_START` while `bus_owned` runs the RSTART sequence.
  - `CMD_RSTART` or `CMD_STOP` while not owned is rejected.
  - `cmd`=0 is rejected.
  - A rejected command pulses `cmd_err` in the cycle after accept, causes no line activity and leaves the state unchanged.
- Clock stretching: in `S_RS_SCL` and `S_SP_SCL`, the counter holds at 0 while synchronised `scl_in` is 0. Counting starts once `scl_in` reads 1.
- Arbitration: at the end of `S_ST_SETUP` or `S_SP_REL`, if synchronised `sda_in` is 0:
  - `arb_lost` pulses.
  - Both lines are released.
  - `bus_owned` clears and the state returns to `S_IDLE`.
  - `done` is not pulsed.
- Reset mid-operation: all lines are released immediately (asynchronous) and `bus_owned` clears.

## Timing
- All outputs are registered.
- Latency, measured from the accept edge to the edge that raises `done`, with no stretching:
  - START: 3(D+1) cycles.
  - RSTART: 4(D+1) cycles.
  - STOP: 3(D+1) cycles.
- `done` and `cmd_ready` rise on the same edge. A new command may be accepted in the `done` cycle.
- `bus_owned` changes on the same edge as `done`. On arbitration loss it changes on the same edge as `arb_lost`.
- The synchroniser adds 2 cycles. Stretch release is therefore seen 2 cycles after `scl_in` rises, and the affected phase lasts D+3 cycles beyond the stretch.
- Changing `dbl_clock_divisor` mid-condition has no effect until the next accept.

## Structure
- Package `i2c_pkg` holds:
  - `cmd` encodings `CMD_START`, `CMD_RSTART`, `CMD_STOP`.
  - The condition-state enum.
  - The shared `k_*` state constants.
- Sub-module `i2c_sync2`: two-flop synchroniser with reset value 1, instantiated once for `scl_in` and once for `sda_in`.

## Test plan
- START with D=3, lines pulled high: `sda_out` falls 4 cycles after accept and `scl_out` falls 8 cycles after accept. `done` pulses at cycle 12 and `bus_owned`=1.
- RSTART then STOP with D=0: the RSTART sequence is (0,1),(1,1),(1,0),(0,0), one cycle per phase, with `done` at cycle 4. The STOP then ends with (1,1), `bus_owned`=0, and `done` at cycle 3.
- Stretch: during STOP with D=2, hold `scl_in` low for 10 cycles in `S_SP_SCL`. `S_SP_SCL` lasts 15 cycles and `done` is delayed by 12 cycles.
- Arbitration: force `sda_in`=0 during `S_ST_SETUP`. `arb_lost` pulses, outputs are (1,1), `done` stays 0 and `bus_owned`=0.
- Rejection and reset: STOP while idle gives a `cmd_err` pulse and no line change. Asserting `rst_n` low mid-RSTART releases both lines immediately and `cmd_ready`=1.
